axis_pkt_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one AXI-Stream output register stage between N AXI-Stream requesters.
- Holds a grant from the first beat of a packet through its tlast beat, so packets are never interleaved.
- Tags every output beat with the source port index.
- Sits ahead of the shared downstream stream consumer and replaces ad-hoc muxing of multiple sources.

---
 rtl/axis_pkt_if.sv | 27 ++
 rtl/axis_pkt_arbiter.sv | 112 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_if.sv
// AXI-Stream bundle for the packet arbiter: N packed requester lanes plus one shared output.
// The master modport is the arbiter's view; slave is the sources/sink environment.
interface axis_pkt_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int IW = 2
);
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tlast;
   logic [N-1:0]    s_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tvalid;
   logic            m_tlast;
   logic [IW-1:0]   m_tid;
   logic            m_tready;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
   );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter: one grant is held from first beat to tlast,
// feeding a single registered AXI-Stream output tagged with the source index.
module axis_pkt_arbiter #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int IW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] port_en_i,
   output logic         busy_o,
   axis_pkt_if.master   bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_grant_q, last_grant_d;
   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic [N-1:0]    req;
   logic [N-1:0]    s_ready;
   logic            ready_ok;
   logic            accept;
   logic [DW-1:0]   m_tdata_q;
   logic            m_tvalid_q;
   logic            m_tlast_q;
   logic [IW-1:0]   m_tid_q;

   assign req = bus.s_tvalid & port_en_i;

   // Walk from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin : rr_pick
      int cand;
      cand     = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = N; i >= 1; i--) begin
         cand = int'(last_grant_q) + i;
         if (cand >= N) cand = cand - N;
         if (req[cand]) begin
            pick     = IW'(cand);
            pick_vld = 1'b1;
         end
      end
   end

   // Ready depends only on registered state and m_tready, never on s_tvalid.
   assign ready_ok = !m_tvalid_q || bus.m_tready;
   assign accept   = (state_q == BUSY) && bus.s_tvalid[grant_q] && ready_ok;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign s_ready[gi] = (state_q == BUSY) && (grant_q == IW'(gi)) && ready_ok;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept && bus.s_tlast[grant_q]) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IW'(N - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
      end else if (accept) begin
         m_tdata_q  <= bus.s_tdata[grant_q*DW +: DW];
         m_tlast_q  <= bus.s_tlast[grant_q];
         m_tid_q    <= grant_q;
         m_tvalid_q <= 1'b1;
      end else if (bus.m_tready) begin
         m_tvalid_q <= 1'b0;
      end
   end

   assign bus.s_tready = s_ready;
   assign bus.m_tdata  = m_tdata_q;
   assign bus.m_tvalid = m_tvalid_q;
   assign bus.m_tlast  = m_tlast_q;
   assign bus.m_tid    = m_tid_q;
   assign busy_o       = (state_q == BUSY);
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: behavioural packet sources, an output monitor,
// and a table of expected output beats per scenario plus hand-written corner sequences.
module tb_axis_pkt_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] port_en = '1;
   logic         busy;

   always #5 clk = ~clk;

   axis_pkt_if #(.N(N), .DW(DW), .IW(IW)) bus ();

   axis_pkt_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .port_en_i (port_en),
      .busy_o    (busy),
      .bus       (bus)
   );

   typedef struct {
      int            test;
      logic [IW-1:0] tid;
      logic [DW-1:0] data;
      logic          last;
      int            rel;
   } vec_t;

   typedef struct {
      logic [IW-1:0] tid;
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } beat_t;

   vec_t  vecs[$];
   beat_t out_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rdy_mode = 0;

   bit [N-1:0]    src_on;
   bit [N-1:0]    stall;
   int            cnt[N];
   int            len[N];
   int            pkts_done[N];
   int            pkt_max[N];
   int            beats_sent[N];
   logic [DW-1:0] base[N];

   logic          prev_hold;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [IW-1:0] prev_tid;

   function automatic void add(int test, int tid, int data, bit last, int rel);
      vec_t v;
      v.test = test;
      v.tid  = IW'(tid);
      v.data = DW'(data);
      v.last = last;
      v.rel  = rel;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   task automatic drive_sources();
      for (int i = 0; i < N; i++) begin
         bus.s_tvalid[i]          = src_on[i] && !stall[i] && (pkts_done[i] < pkt_max[i]);
         bus.s_tlast[i]           = (cnt[i] == len[i] - 1);
         bus.s_tdata[i*DW +: DW]  = base[i] | DW'(cnt[i]);
      end
      bus.m_tready = (rdy_mode == 0) || (cyc % 3 == 0);
   endtask

   // One clock: sample at negedge+1, step the edge, then update the source models.
   task automatic cycle();
      bit [N-1:0] hs;
      beat_t b;
      #1;
      if (prev_hold) begin
         chk("hold_valid", int'(bus.m_tvalid), 1);
         chk("hold_data", int'(bus.m_tdata), int'(prev_data));
         chk("hold_last", int'(bus.m_tlast), int'(prev_last));
         chk("hold_tid", int'(bus.m_tid), int'(prev_tid));
      end
      prev_hold = bus.m_tvalid && !bus.m_tready;
      prev_data = bus.m_tdata;
      prev_last = bus.m_tlast;
      prev_tid  = bus.m_tid;
      if (bus.m_tvalid && bus.m_tready) begin
         b.tid  = bus.m_tid;
         b.data = bus.m_tdata;
         b.last = bus.m_tlast;
         b.cyc  = cyc;
         out_q.push_back(b);
         $display("beat cyc=%0d tid=%0d data=%02h last=%0b", cyc, b.tid, b.data, b.last);
      end
      for (int i = 0; i < N; i++) hs[i] = bus.s_tvalid[i] && bus.s_tready[i];
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            beats_sent[i]++;
            if (cnt[i] == len[i] - 1) begin
               cnt[i] = 0;
               pkts_done[i]++;
            end else begin
               cnt[i]++;
            end
         end
      end
      drive_sources();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      prev_hold = 1'b0;
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         len[i] = 3;
         pkts_done[i] = 0;
         pkt_max[i] = 1000;
         beats_sent[i] = 0;
         base[i] = DW'(i * 16);
      end
      src_on = '0;
      stall = '0;
      port_en = '1;
      rdy_mode = 0;
      cyc = 0;
      drive_sources();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_q.delete();
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   task automatic compare(int test, string name);
      int k = 0;
      int first = (out_q.size() > 0) ? out_q[0].cyc : 0;
      foreach (vecs[j]) begin
         if (vecs[j].test == test) begin
            if (k >= out_q.size()) begin
               n_cmp++;
               n_fail++;
               $display("FAIL %s beat %0d: missing, got %0d beats", name, k, out_q.size());
            end else begin
               chk($sformatf("%s[%0d].tid", name, k), int'(out_q[k].tid), int'(vecs[j].tid));
               chk($sformatf("%s[%0d].data", name, k), int'(out_q[k].data), int'(vecs[j].data));
               chk($sformatf("%s[%0d].last", name, k), int'(out_q[k].last), int'(vecs[j].last));
               if (vecs[j].rel >= 0)
                  chk($sformatf("%s[%0d].cycle", name, k), out_q[k].cyc - first, vecs[j].rel);
            end
            k++;
         end
      end
   endtask

   initial begin
      // Expected beats: data = {port, beat} unless a test overrides the base.
      for (int k = 0; k < 5; k++)
         for (int b = 0; b < 3; b++)
            add(1, k % 4, (k % 4) * 16 + b, b == 2, 4 * k + b);
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < 3; b++)
            add(2, (k % 2 == 0) ? 1 : 3, ((k % 2 == 0) ? 16 : 48) + b, b == 2, 4 * k + b);
      for (int b = 0; b < 4; b++) add(3, 2, 8'hA0 + b, b == 3, -1);
      for (int b = 0; b < 3; b++) add(4, 1, 8'h10 + b, b == 2, -1);
      for (int k = 0; k < 2; k++)
         for (int b = 0; b < 3; b++) add(4, 3, 8'h30 + b, b == 2, -1);
      for (int b = 0; b < 4; b++) add(5, 1, 8'h10 + b, b == 3, -1);
      for (int b = 0; b < 4; b++) add(5, 3, 8'h30 + b, b == 3, -1);
      for (int k = 0; k < 6; k++) add(6, 0, 8'h00, 1'b1, 2 * k);

      #2;
      do_reset();
      #1;
      chk("rst_m_tvalid", int'(bus.m_tvalid), 0);
      chk("rst_m_tlast", int'(bus.m_tlast), 0);
      chk("rst_m_tdata", int'(bus.m_tdata), 0);
      chk("rst_m_tid", int'(bus.m_tid), 0);
      chk("rst_s_tready", int'(bus.s_tready), 0);
      chk("rst_busy", int'(busy), 0);

      // Async reset mid-packet: everything drops before any clock edge.
      src_on = '1;
      drive_sources();
      for (int t = 0; t < 10 && !bus.m_tvalid; t++) cycle();
      if (!bus.m_tvalid) fail_now("pre_reset_output");
      rst_n = 1'b0;
      #1;
      chk("async_m_tvalid", int'(bus.m_tvalid), 0);
      chk("async_m_tlast", int'(bus.m_tlast), 0);
      chk("async_s_tready", int'(bus.s_tready), 0);
      chk("async_busy", int'(busy), 0);

      do_reset();
      src_on = '1;
      drive_sources();
      run(26);
      compare(1, "rr");

      do_reset();
      src_on = '1;
      port_en = 4'b1010;
      drive_sources();
      run(22);
      compare(2, "mask");

      do_reset();
      src_on = 4'b0100;
      len[2] = 4;
      pkt_max[2] = 1;
      base[2] = 8'hA0;
      rdy_mode = 1;
      drive_sources();
      run(30);
      compare(3, "bp");
      chk("bp_count", out_q.size(), 4);

      do_reset();
      src_on = 4'b1010;
      drive_sources();
      for (int t = 0; t < 20 && beats_sent[1] < 1; t++) cycle();
      if (beats_sent[1] < 1) fail_now("en_mid_first_beat");
      port_en[1] = 1'b0;
      run(20);
      compare(4, "en_mid");

      do_reset();
      src_on = 4'b1010;
      len[1] = 4;
      len[3] = 4;
      drive_sources();
      for (int t = 0; t < 20 && beats_sent[1] < 2; t++) cycle();
      if (beats_sent[1] < 2) fail_now("stall_setup");
      stall[1] = 1'b1;
      drive_sources();
      for (int t = 0; t < 5; t++) begin
         #1;
         chk("stall_busy", int'(busy), 1);
         chk("stall_ready3", int'(bus.s_tready[3]), 0);
         cycle();
      end
      stall[1] = 1'b0;
      drive_sources();
      run(20);
      compare(5, "stall");

      do_reset();
      src_on = 4'b0001;
      len[0] = 1;
      drive_sources();
      run(18);
      compare(6, "single");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
